// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch and Memory stage), the memory
// array and the arbiter that shares the single memory port between them.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    // Fetch requester
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          i_stall;

    // Data requester
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_stall;

    // Memory array port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, i_stall,
        output d_gnt, d_rvalid, d_rdata, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_stall,
        input  d_gnt, d_rvalid, d_rdata, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and Memory-stage
// load/store (D). D wins by default; a starvation counter forces an I grant
// after STARVE_MAX consecutive denied I cycles. Each read is tagged so the
// synchronous-read data returns to the right requester one cycle later.
module mem_port_arbiter #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 8,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StRdI,
        StRdD
    } tag_e;

    tag_e          tag_q, tag_d;
    logic [3:0]    starve_q, starve_d;

    logic          force_i;
    logic          i_gnt;
    logic          d_gnt;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          i_rvalid;
    logic          d_rvalid;
    logic [DW-1:0] i_rdata;
    logic [DW-1:0] d_rdata;

    // Grant decision: D has priority unless fetch has starved long enough.
    always_comb begin
        force_i = bus.i_req & (starve_q == StarveMax);
        d_gnt   = ~rst & bus.d_req & ~force_i;
        i_gnt   = ~rst & bus.i_req & ~d_gnt;
    end

    // Memory port mux; idle port drives all zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.d_we;
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
        end else if (i_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = bus.i_addr;
        end
    end

    // Next-state for the starvation counter and the read-return tag.
    always_comb begin
        starve_d = starve_q;
        tag_d    = StIdle;
        if (bus.i_req & ~i_gnt) begin
            if (starve_q < StarveMax) begin
                starve_d = starve_q + 4'd1;
            end
        end else begin
            starve_d = 4'd0;
        end
        // Stores leave the tag idle: nothing comes back from the array.
        if (d_gnt & ~bus.d_we) begin
            tag_d = StRdD;
        end else if (i_gnt) begin
            tag_d = StRdI;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 4'd0;
            tag_q    <= StIdle;
        end else begin
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

    // Route returning read data; rst masks a read granted just before reset.
    always_comb begin
        i_rvalid = ~rst & (tag_q == StRdI);
        d_rvalid = ~rst & (tag_q == StRdD);
        i_rdata  = i_rvalid ? bus.mem_rdata : '0;
        d_rdata  = d_rvalid ? bus.mem_rdata : '0;
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.i_stall   = bus.i_req & ~i_gnt;
    assign bus.d_stall   = bus.d_req & ~d_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_rvalid  = i_rvalid;
    assign bus.i_rdata   = i_rdata;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.d_rdata   = d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous-read memory.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

    mem_port_arbiter #(
        .AW         (8),
        .DW         (8),
        .STARVE_MAX (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial memory contents: mem[0x10]=0xA5, otherwise addr ^ 0x5A.
    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    logic [7:0] mem [256];

    // Synchronous-read memory; reloaded with its initial image on reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
            bus.mem_rdata <= 8'h00;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.i_req   = 1'b0;
        bus.i_addr  = 8'h00;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h00;
        bus.d_wdata = 8'h00;
    endtask

    bit         gnt_pat [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    bit         prev_i;
    logic [7:0] prev_addr;
    logic [7:0] a;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        bus.i_req  = 1'b1;
        bus.i_addr = 8'h10;
        bus.d_req  = 1'b1;
        bus.d_addr = 8'h20;

        // Reset: everything quiet even with both requests held.
        sample();
        check("rst_i_gnt", bus.i_gnt, 0);
        check("rst_d_gnt", bus.d_gnt, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_i_rvalid", bus.i_rvalid, 0);
        check("rst_d_rvalid", bus.d_rvalid, 0);
        step();
        rst = 1'b0;
        sample();
        check("rel_d_gnt", bus.d_gnt, 1);
        check("rel_i_gnt", bus.i_gnt, 0);
        check("rel_mem_addr", bus.mem_addr, 8'h20);
        check("rel_i_stall", bus.i_stall, 1);
        step();
        idle();
        sample();
        check("rel_d_rvalid", bus.d_rvalid, 1);
        check("rel_d_rdata", bus.d_rdata, 8'h7A);
        step();

        // 1: fetch alone.
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = 8'h10;
        sample();
        check("t1_i_gnt", bus.i_gnt, 1);
        check("t1_mem_en", bus.mem_en, 1);
        check("t1_mem_addr", bus.mem_addr, 8'h10);
        check("t1_i_stall", bus.i_stall, 0);
        step();
        idle();
        sample();
        check("t1_i_rvalid", bus.i_rvalid, 1);
        check("t1_i_rdata", bus.i_rdata, 8'hA5);
        check("t1_d_rvalid", bus.d_rvalid, 0);
        check("t1_d_rdata", bus.d_rdata, 0);

        // 2: load beats fetch, then fetch goes.
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = 8'h11;
        bus.d_req  = 1'b1;
        bus.d_addr = 8'h20;
        sample();
        check("t2_d_gnt", bus.d_gnt, 1);
        check("t2_i_gnt", bus.i_gnt, 0);
        check("t2_i_stall", bus.i_stall, 1);
        check("t2_d_stall", bus.d_stall, 0);
        check("t2_mem_addr", bus.mem_addr, 8'h20);
        step();
        bus.d_req = 1'b0;
        sample();
        check("t2_d_rvalid", bus.d_rvalid, 1);
        check("t2_d_rdata", bus.d_rdata, 8'h7A);
        check("t2_i_rvalid0", bus.i_rvalid, 0);
        check("t2_i_gnt2", bus.i_gnt, 1);
        check("t2_mem_addr2", bus.mem_addr, 8'h11);
        step();
        idle();
        sample();
        check("t2_i_rvalid", bus.i_rvalid, 1);
        check("t2_i_rdata", bus.i_rdata, 8'h4B);
        check("t2_d_rvalid0", bus.d_rvalid, 0);

        // 3: both held, grants D,D,D,I repeating.
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = 8'h41;
        bus.d_req  = 1'b1;
        bus.d_addr = 8'h40;
        for (int k = 0; k < 8; k++) begin
            sample();
            check($sformatf("t3_i_gnt%0d", k), bus.i_gnt, gnt_pat[k]);
            check($sformatf("t3_d_gnt%0d", k), bus.d_gnt, !gnt_pat[k]);
            if (k < 7) step();
        end
        step();
        idle();
        sample();

        // 4: store, then read back.
        step();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 8'h30;
        bus.d_wdata = 8'h5C;
        sample();
        check("t4_d_gnt", bus.d_gnt, 1);
        check("t4_mem_we", bus.mem_we, 1);
        check("t4_mem_addr", bus.mem_addr, 8'h30);
        check("t4_mem_wdata", bus.mem_wdata, 8'h5C);
        step();
        idle();
        sample();
        check("t4_no_rvalid", bus.d_rvalid, 0);
        check("t4_we_drop", bus.mem_we, 0);
        step();
        bus.d_req  = 1'b1;
        bus.d_addr = 8'h30;
        sample();
        check("t4_rd_gnt", bus.d_gnt, 1);
        check("t4_rd_we", bus.mem_we, 0);
        step();
        idle();
        sample();
        check("t4_rd_rvalid", bus.d_rvalid, 1);
        check("t4_rd_rdata", bus.d_rdata, 8'h5C);

        // Store and fetch together: store first, fetch next cycle.
        step();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 8'h31;
        bus.d_wdata = 8'h77;
        bus.i_req   = 1'b1;
        bus.i_addr  = 8'h32;
        sample();
        check("sf_d_gnt", bus.d_gnt, 1);
        check("sf_i_gnt", bus.i_gnt, 0);
        check("sf_mem_we", bus.mem_we, 1);
        check("sf_mem_addr", bus.mem_addr, 8'h31);
        step();
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        sample();
        check("sf_i_gnt2", bus.i_gnt, 1);
        check("sf_mem_we2", bus.mem_we, 0);
        check("sf_mem_addr2", bus.mem_addr, 8'h32);
        check("sf_d_rvalid", bus.d_rvalid, 0);
        step();
        idle();
        sample();
        check("sf_i_rvalid", bus.i_rvalid, 1);
        check("sf_i_rdata", bus.i_rdata, 8'h68);

        // 5a: starve the fetch to the limit, then reset clears the counter.
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = 8'h12;
        bus.d_req  = 1'b1;
        bus.d_addr = 8'h20;
        for (int k = 0; k < 3; k++) begin
            sample();
            check($sformatf("t5a_d_gnt%0d", k), bus.d_gnt, 1);
            step();
        end
        rst = 1'b1;
        sample();
        check("t5a_rst_d_rvalid", bus.d_rvalid, 0);
        check("t5a_rst_d_rdata", bus.d_rdata, 0);
        check("t5a_rst_d_gnt", bus.d_gnt, 0);
        check("t5a_rst_mem_en", bus.mem_en, 0);
        step();
        rst = 1'b0;
        sample();
        check("t5a_post_d_gnt", bus.d_gnt, 1);
        check("t5a_post_i_gnt", bus.i_gnt, 0);
        check("t5a_post_d_rvalid", bus.d_rvalid, 0);

        // 5b: fetch granted right before reset never returns data.
        step();
        bus.d_req  = 1'b0;
        bus.i_addr = 8'h10;
        sample();
        check("t5b_i_gnt", bus.i_gnt, 1);
        step();
        rst = 1'b1;
        sample();
        check("t5b_rst_i_rvalid", bus.i_rvalid, 0);
        check("t5b_rst_i_rdata", bus.i_rdata, 0);
        check("t5b_rst_i_gnt", bus.i_gnt, 0);
        step();
        rst = 1'b0;
        sample();
        check("t5b_post_i_gnt", bus.i_gnt, 1);
        check("t5b_post_i_rvalid", bus.i_rvalid, 0);
        step();
        idle();
        sample();
        check("t5b_i_rvalid", bus.i_rvalid, 1);
        check("t5b_i_rdata", bus.i_rdata, 8'hA5);

        // 6: alternating I/D reads, one per cycle.
        prev_i    = 1'b0;
        prev_addr = 8'h00;
        for (int k = 0; k < 7; k++) begin
            step();
            idle();
            a = 8'(k < 6 ? ((k % 2 == 0) ? 8'h50 : 8'h60) + k : 0);
            if (k < 6) begin
                if (k % 2 == 0) begin
                    bus.i_req  = 1'b1;
                    bus.i_addr = a;
                end else begin
                    bus.d_req  = 1'b1;
                    bus.d_addr = a;
                end
            end
            sample();
            if (k < 6) begin
                check($sformatf("t6_i_gnt%0d", k), bus.i_gnt, (k % 2 == 0) ? 1 : 0);
                check($sformatf("t6_d_gnt%0d", k), bus.d_gnt, (k % 2 == 0) ? 0 : 1);
            end
            if (k > 0) begin
                check($sformatf("t6_i_rvalid%0d", k), bus.i_rvalid, prev_i ? 1 : 0);
                check($sformatf("t6_d_rvalid%0d", k), bus.d_rvalid, prev_i ? 0 : 1);
                check($sformatf("t6_i_rdata%0d", k), bus.i_rdata,
                      prev_i ? (prev_addr ^ 8'h5A) : 0);
                check($sformatf("t6_d_rdata%0d", k), bus.d_rdata,
                      prev_i ? 0 : (prev_addr ^ 8'h5A));
            end
            prev_i    = (k % 2 == 0);
            prev_addr = a;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
